button_debouncer: RTL



---
 rtl/button_pkg.sv | 15 +
 rtl/button_debouncer_if.sv | 26 ++
 rtl/ms_tick_gen.sv | 29 ++
 rtl/button_debouncer.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and default constants for the pushbutton debouncer and its time base.
package button_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_PEND,
        PRESSED,
        REL_PEND
    } btn_state_t;

    localparam int CLK_DIV_DEF       = 50000;
    localparam int DEBOUNCE_MS_DEF   = 20;
    localparam int LONG_PRESS_MS_DEF = 1000;

endpackage

// File: rtl/button_debouncer_if.sv
// Button pin plus the debounced level and event pulses handed to control logic.
interface button_debouncer_if;

    logic BTN_IN;
    logic BTN_LEVEL;
    logic BTN_PRESS;
    logic BTN_RELEASE;
    logic BTN_LONG;

    modport master (
        output BTN_IN,
        input  BTN_LEVEL,
        input  BTN_PRESS,
        input  BTN_RELEASE,
        input  BTN_LONG
    );

    modport slave (
        input  BTN_IN,
        output BTN_LEVEL,
        output BTN_PRESS,
        output BTN_RELEASE,
        output BTN_LONG
    );

endinterface

// File: rtl/ms_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every CLK_DIV clocks.
module ms_tick_gen
    import button_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic CLK,
    input  logic RST,
    output logic tick
);

    localparam int            CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/button_debouncer.sv
// Synchronises and debounces a raw pushbutton on a 1 ms time base, emitting
// a clean level plus press, release and long-press pulses.
module button_debouncer
    import button_pkg::*;
#(
    parameter int CLK_DIV       = CLK_DIV_DEF,
    parameter int DEBOUNCE_MS   = DEBOUNCE_MS_DEF,
    parameter int LONG_PRESS_MS = LONG_PRESS_MS_DEF
) (
    input  logic               CLK,
    input  logic               RST,
    button_debouncer_if.slave  btn
);

    localparam int                DB_W     = $clog2(DEBOUNCE_MS + 1);
    localparam int                HOLD_W   = $clog2(LONG_PRESS_MS + 1);
    localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_MS);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_MS);

    function automatic logic [HOLD_W-1:0] hold_sat_inc(input logic [HOLD_W-1:0] v);
        return (v == HOLD_MAX) ? v : v + 1'b1;
    endfunction

    logic tick;

    ms_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .CLK  (CLK),
        .RST  (RST),
        .tick (tick)
    );

    // Stage p0/p1: two-flop synchroniser on the asynchronous pin
    logic sync_p0;
    logic sync_p1;
    logic btn_s;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= btn.BTN_IN;
            sync_p1 <= sync_p0;
        end
    end

    assign btn_s = sync_p1;

    // Stage p2: debounce state machine with registered outputs
    btn_state_t        state, state_nxt;
    logic [DB_W-1:0]   db_cnt, db_nxt, db_inc;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt, hold_inc;
    logic              level_r, press_r, rel_r, long_r;
    logic              level_nxt, press_nxt, rel_nxt, long_nxt;

    assign db_inc   = db_cnt + 1'b1;
    assign hold_inc = hold_sat_inc(hold_cnt);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= RELEASED;
            db_cnt   <= '0;
            hold_cnt <= '0;
            level_r  <= 1'b0;
            press_r  <= 1'b0;
            rel_r    <= 1'b0;
            long_r   <= 1'b0;
        end else begin
            state    <= state_nxt;
            db_cnt   <= db_nxt;
            hold_cnt <= hold_nxt;
            level_r  <= level_nxt;
            press_r  <= press_nxt;
            rel_r    <= rel_nxt;
            long_r   <= long_nxt;
        end
    end

    // A revert of btn_s is checked before any tick so a coincident tick is discarded.
    always_comb begin
        state_nxt = state;
        db_nxt    = db_cnt;
        hold_nxt  = hold_cnt;
        level_nxt = level_r;
        press_nxt = 1'b0;
        rel_nxt   = 1'b0;
        long_nxt  = 1'b0;
        unique case (state)
            RELEASED: begin
                if (btn_s) begin
                    state_nxt = PRESS_PEND;
                    db_nxt    = '0;
                end
            end
            PRESS_PEND: begin
                if (!btn_s) begin
                    state_nxt = RELEASED;
                end else if (tick) begin
                    db_nxt = db_inc;
                    if (db_inc == DB_MAX) begin
                        state_nxt = PRESSED;
                        level_nxt = 1'b1;
                        press_nxt = 1'b1;
                        hold_nxt  = '0;
                    end
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_nxt = REL_PEND;
                    db_nxt    = '0;
                end else if (tick) begin
                    hold_nxt = hold_inc;
                    long_nxt = (hold_inc == HOLD_MAX) && (hold_cnt != HOLD_MAX);
                end
            end
            REL_PEND: begin
                if (btn_s) begin
                    state_nxt = PRESSED;
                end else if (tick) begin
                    db_nxt = db_inc;
                    if (db_inc == DB_MAX) begin
                        state_nxt = RELEASED;
                        level_nxt = 1'b0;
                        rel_nxt   = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = RELEASED;
            end
        endcase
    end

    assign btn.BTN_LEVEL   = level_r;
    assign btn.BTN_PRESS   = press_r;
    assign btn.BTN_RELEASE = rel_r;
    assign btn.BTN_LONG    = long_r;

endmodule
